// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the RV32M multiply/divide execute unit.
package muldiv_unit_pkg;

    localparam int unsigned MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } md_sign_t;

    // Operand signedness implied by the M-extension opcode.
    function automatic md_sign_t md_signs(input logic [2:0] f3);
        md_sign_t s;
        s = '0;
        case (f3)
            F3_MULH, F3_DIV, F3_REM: s = '{a_signed: 1'b1, b_signed: 1'b1};
            F3_MULHSU:               s.a_signed = 1'b1;
            default:                 s = '0;
        endcase
        return s;
    endfunction

    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic md_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Iterative engine: restoring divider, reused as a shift-add multiplier.
// hi/lo hold remainder/quotient for division and product[63:32]/[31:0] for multiply.
module muldiv_unit_div_iter
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_mul,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last_c,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [MD_CNT_W-1:0] r_cnt;
    logic                r_run;
    logic                r_mul;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;

    logic [XLEN-1:0]     w_shift_hi;
    logic [XLEN:0]       w_trial;
    logic                w_ge;
    logic [XLEN-1:0]     w_addend;
    logic [XLEN:0]       w_sum;
    logic [XLEN-1:0]     w_nxt_hi;
    logic [XLEN-1:0]     w_nxt_lo;

    // Shifted remainder is XLEN+1 bits wide; its top bit alone guarantees it exceeds the divisor.
    assign w_shift_hi = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    assign w_trial    = {r_hi, r_lo[XLEN-1]} - {1'b0, i_b};
    assign w_ge       = r_hi[XLEN-1] | ~w_trial[XLEN];
    assign w_addend   = r_lo[0] ? i_b : '0;
    assign w_sum      = {1'b0, r_hi} + {1'b0, w_addend};

    always_comb begin
        w_nxt_hi = w_shift_hi;
        w_nxt_lo = {r_lo[XLEN-2:0], 1'b0};
        if (r_mul) begin
            w_nxt_hi = w_sum[XLEN:1];
            w_nxt_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end else if (w_ge) begin
            w_nxt_hi = w_trial[XLEN-1:0];
            w_nxt_lo = {r_lo[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
            r_mul <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (i_abort) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_mul <= i_mul;
            r_cnt <= MD_CNT_W'(XLEN - 1);
            r_hi  <= '0;
            r_lo  <= i_a;
        end else if (r_run) begin
            r_hi <= w_nxt_hi;
            r_lo <= w_nxt_lo;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - MD_CNT_W'(1);
            end
        end
    end

    assign o_last_c = r_run && (r_cnt == '0);
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit with start/busy/done handshake.
// Owns the control FSM, sign handling and the RISC-V division special cases.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned      XW2  = 2 * XLEN;
    localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       r_state;
    logic [2:0]      r_op;
    logic            r_neg;
    logic            r_neg_rem;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    md_sign_t        w_sign;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;
    logic            w_iter_start;
    logic            w_fast_calc;
    logic            w_last;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XW2-1:0]  w_fast_prod;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_res;

    // Sign-correct a full product and pick the half the opcode asks for.
    function automatic logic [XLEN-1:0] mul_pick(input logic [XW2-1:0] p, input logic neg,
                                                 input logic [2:0] op);
        logic [XW2-1:0] s;
        s = neg ? -p : p;
        return (op == F3_MUL) ? s[XLEN-1:0] : s[XW2-1:XLEN];
    endfunction

    assign w_sign  = md_signs(funct3);
    assign w_a_neg = w_sign.a_signed & rs1_data[XLEN-1];
    assign w_b_neg = w_sign.b_signed & rs2_data[XLEN-1];
    assign w_abs_a = w_a_neg ? -rs1_data : rs1_data;
    assign w_abs_b = w_b_neg ? -rs2_data : rs2_data;

    assign w_div0    = (rs2_data == '0);
    assign w_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (rs1_data == SMIN) && (rs2_data == '1);
    assign w_special = md_is_div(funct3) & (w_div0 | w_ovf);

    always_comb begin
        w_special_res = '1;
        if (w_div0) begin
            w_special_res = md_is_rem(funct3) ? rs1_data : '1;
        end else if (md_is_rem(funct3)) begin
            w_special_res = '0;
        end else begin
            w_special_res = SMIN;
        end
    end

    // The single-cycle product path bypasses the iterative engine entirely.
    assign w_accept     = (r_state == MD_IDLE) & start & ~flush;
    assign w_iter_start = w_accept & ~w_special & ~(FAST_MUL & ~md_is_div(funct3));
    assign w_fast_calc  = FAST_MUL & ~md_is_div(r_op);

    muldiv_unit_div_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_iter_start),
        .i_abort  (flush),
        .i_mul    (~md_is_div(funct3)),
        .i_a      (w_abs_a),
        .i_b      (r_opb),
        .o_last_c (w_last),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    assign w_fast_prod = XW2'(r_opa) * XW2'(r_opb);
    assign w_fast_res  = mul_pick(w_fast_prod, r_neg, r_op);
    assign w_quo       = r_neg ? -w_lo : w_lo;
    assign w_rem       = r_neg_rem ? -w_hi : w_hi;

    always_comb begin
        w_fix_res = mul_pick({w_hi, w_lo}, r_neg, r_op);
        if (md_is_div(r_op)) begin
            w_fix_res = md_is_rem(r_op) ? w_rem : w_quo;
        end
    end

    // Control FSM; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush && (r_state != MD_IDLE)) begin
                r_state <= MD_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    MD_IDLE: begin
                        if (w_accept) begin
                            r_op      <= funct3;
                            r_neg     <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_opa     <= w_abs_a;
                            r_opb     <= w_abs_b;
                            if (w_special) begin
                                r_state  <= MD_DONE;
                                r_done   <= 1'b1;
                                r_result <= w_special_res;
                            end else begin
                                r_state <= MD_CALC;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    MD_CALC: begin
                        if (w_fast_calc) begin
                            r_state  <= MD_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_fast_res;
                        end else if (w_last) begin
                            r_state <= MD_FIX;
                        end
                    end
                    MD_FIX: begin
                        r_state  <= MD_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_fix_res;
                    end
                    MD_DONE: begin
                        r_state <= MD_IDLE;
                    end
                    default: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one FAST_MUL=1 and one FAST_MUL=0 instance against a cycle-level reference model.
module tb_muldiv_unit;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        flush  = 1'b0;
    logic [1:0]  start  = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1    = '0;
    logic [31:0] rs2    = '0;

    logic [1:0]       busy_w;
    logic [1:0]       done_w;
    logic [1:0][31:0] res_w;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance (0 = fast multiply, 1 = iterative multiply)
    logic [1:0]       m_inflight = '0;
    logic [1:0]       m_busy     = '0;
    logic [1:0]       m_done     = '0;
    logic [1:0][31:0] m_exp      = '0;
    logic [1:0][31:0] m_result   = '0;
    int               m_cyc [2];
    int               m_lat [2];
    bit               m_live     = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .rst(rst), .start(start[0]), .funct3(funct3), .rs1_data(rs1), .rs2_data(rs2),
        .flush(flush), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]));

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (
        .clk(clk), .rst(rst), .start(start[1]), .funct3(funct3), .rs1_data(rs1), .rs2_data(rs2),
        .flush(flush), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]));

    // RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (f)
            3'd0:    p = ua * ub;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * longint'(ub);
            3'd3:    p = ua * ub;
            default: p = '0;
        endcase
        case (f)
            3'd0:             return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:             return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5:             return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6:             return (b == 0) ? a : 32'(sa % sb);
            default:          return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_latency(input bit fast, input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return fast ? 2 : 34;
    endfunction

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: advance the handshake view of each instance at every rising edge.
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            logic was_done;
            was_done  = m_done[k];
            m_done[k] = 1'b0;
            if (rst) begin
                m_inflight[k] = 1'b0;
                m_busy[k]     = 1'b0;
                m_result[k]   = '0;
            end else if (m_inflight[k]) begin
                if (was_done) begin
                    m_inflight[k] = 1'b0;
                end else if (flush) begin
                    m_inflight[k] = 1'b0;
                    m_busy[k]     = 1'b0;
                end else begin
                    m_cyc[k]++;
                    if (m_cyc[k] == m_lat[k]) begin
                        m_done[k]   = 1'b1;
                        m_busy[k]   = 1'b0;
                        m_result[k] = m_exp[k];
                    end
                end
            end else if (start[k] && !flush) begin
                m_inflight[k] = 1'b1;
                m_cyc[k]      = 1;
                m_lat[k]      = ref_latency(k == 0, funct3, rs1, rs2);
                m_exp[k]      = ref_result(funct3, rs1, rs2);
                if (m_lat[k] == 1) begin
                    m_done[k]   = 1'b1;
                    m_result[k] = m_exp[k];
                end else begin
                    m_busy[k] = 1'b1;
                end
            end
        end
        if (rst) m_live = 1'b1;
    end

    // Compare every output of both instances against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                check_val($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
                check_val($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
                check_val($sformatf("result[%0d]", k), res_w[k], m_result[k]);
            end
        end
    end

    // Hold start until done, then check latency and result against the given expectations.
    task automatic run_op(input int k, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input string nm);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 1'b0;
        @(negedge clk);
        funct3   = f;
        rs1      = a;
        rs2      = b;
        start[k] = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_w[k]) got = 1'b1;
        end
        start[k] = 1'b0;
        check_val({nm, " done seen"}, 32'(got), 32'd1);
        check_val({nm, " latency"}, 32'(cyc), 32'(lat));
        check_val({nm, " value"}, res_w[k], exp);
    endtask

    task automatic flush_test(input int k, input logic [31:0] held);
        @(negedge clk);
        funct3   = 3'd4;
        rs1      = 32'hFFFF_FFEC;
        rs2      = 32'd3;
        start[k] = 1'b1;
        repeat (10) @(negedge clk);
        start[k] = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush busy", 32'(busy_w[k]), 32'd0);
        check_val("flush done", 32'(done_w[k]), 32'd0);
        check_val("flush result held", res_w[k], held);
        repeat (30) @(negedge clk);
        check_val("flush no late result", res_w[k], held);
    endtask

    task automatic rst_test(input int k);
        @(negedge clk);
        funct3   = 3'd4;
        rs1      = 32'd100;
        rs2      = 32'd7;
        start[k] = 1'b1;
        repeat (5) @(negedge clk);
        start[k] = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst busy", 32'(busy_w[k]), 32'd0);
        check_val("rst done", 32'(done_w[k]), 32'd0);
        check_val("rst result", res_w[k], 32'd0);
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_val("reset busy", 32'(busy_w[k]), 32'd0);
            check_val("reset done", 32'(done_w[k]), 32'd0);
            check_val("reset result", res_w[k], 32'd0);
        end
        rst = 1'b0;

        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "MUL fast");
        run_op(0, 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, "MULH fast");
        run_op(0, 3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 2, "MULHU fast");
        run_op(0, 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, "DIV -20/3");
        run_op(0, 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, "REM -20/3");
        run_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7");
        run_op(0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7");
        flush_test(0, 32'd2);
        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "MUL after flush");
        run_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU by zero");
        run_op(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, "REM by zero");
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV overflow");
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM overflow");
        rst_test(0);

        run_op(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU slow");
        run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL slow");
        run_op(1, 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, "DIV slow inst");

        for (int i = 0; i < 240; i++) begin
            int          k;
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            k = i % 2;
            f = 3'($urandom_range(0, 7));
            a = pick_opnd();
            b = pick_opnd();
            run_op(k, f, a, b, ref_result(f, a, b), ref_latency(k == 0, f, a, b),
                   $sformatf("rand%0d f3=%0d a=%h b=%h", i, f, a, b));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
